// File: rtl/wide_add_seq.sv
// rtl/wide_add_seq.sv - multi-word add/subtract sequencer sharing one 32-bit cla
//
// cla: 32-bit carry-lookahead adder, purely combinational.
//   i_a, i_b  : 32-bit operands
//   i_cin     : carry in
//   o_sum     : 32-bit sum (carry out is rebuilt by the caller from bit 31)
//
// wide_add_seq: two-requester arbiter plus word-serial sequencer.
//   clk, rst                  : clock, asynchronous active-high reset
//   reqN_valid/ready          : request handshake, N = 0,1
//   reqN_a, reqN_b, reqN_sub  : 32*NWORDS operands, 1 = a-b, 0 = a+b
//   resp_valid/ready          : response handshake
//   resp_sum                  : result modulo 2^(32*NWORDS)
//   resp_cout                 : final carry (not-borrow for subtraction)
//   resp_id                   : requester that issued the result

module cla (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_cin,
  output logic [31:0] o_sum
);
  logic [31:0] w_g;
  logic [31:0] w_p;
  logic [31:0] w_c;
  logic [8:0]  w_gc;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  // Two-level lookahead: 4-bit group generate/propagate select group carries,
  // bit carries inside each group are expanded from the group carry-in.
  always_comb begin
    w_gc    = '0;
    w_c     = '0;
    w_gc[0] = i_cin;
    for (int k = 0; k < 8; k++) begin
      w_c[4*k]   = w_gc[k];
      w_c[4*k+1] = w_g[4*k] | (w_p[4*k] & w_gc[k]);
      w_c[4*k+2] = w_g[4*k+1] | (w_p[4*k+1] & w_g[4*k])
                 | (w_p[4*k+1] & w_p[4*k] & w_gc[k]);
      w_c[4*k+3] = w_g[4*k+2] | (w_p[4*k+2] & w_g[4*k+1])
                 | (w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                 | (w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_gc[k]);
      w_gc[k+1]  = w_g[4*k+3] | (w_p[4*k+3] & w_g[4*k+2])
                 | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                 | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                 | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_gc[k]);
    end
  end

  assign o_sum = w_p ^ w_c;
endmodule

module wide_add_seq #(
  parameter int NWORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  logic [32*NWORDS-1:0]   req0_a,
  input  logic [32*NWORDS-1:0]   req0_b,
  input  logic                   req0_sub,
  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  logic [32*NWORDS-1:0]   req1_a,
  input  logic [32*NWORDS-1:0]   req1_b,
  input  logic                   req1_sub,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [32*NWORDS-1:0]   resp_sum,
  output logic                   resp_cout,
  output logic                   resp_id
);
  localparam int W  = 32 * NWORDS;
  localparam int IW = $clog2(NWORDS);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [IW-1:0]   r_idx;
  logic            r_carry;
  logic            r_last;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic            r_sub;
  logic            r_id;
  logic [W-1:0]    r_sum;
  logic            r_cout;
  logic            r_resp_id;
  logic            r_resp_valid;

  logic            w_idle;
  logic            w_accept;
  logic            w_last_word;
  logic [31:0]     w_a_word;
  logic [31:0]     w_b_word;
  logic [31:0]     w_sum_word;
  logic            w_carry_next;

  // On a tie the requester not served last wins; readies are forced low
  // while reset is asserted so nothing is handshaken during reset.
  assign w_idle     = (r_state == S_IDLE) & ~rst;
  assign req0_ready = w_idle & req0_valid & (~req1_valid | r_last);
  assign req1_ready = w_idle & req1_valid & (~req0_valid | ~r_last);
  assign w_accept   = req0_ready | req1_ready;

  assign w_last_word = (r_idx == IW'(NWORDS - 1));
  assign w_a_word    = r_a[32*r_idx +: 32];
  assign w_b_word    = r_sub ? ~r_b[32*r_idx +: 32] : r_b[32*r_idx +: 32];

  cla u_cla (
    .i_a   (w_a_word),
    .i_b   (w_b_word),
    .i_cin (r_carry),
    .o_sum (w_sum_word)
  );

  // Word carry-out rebuilt from the MSBs of operands and sum.
  assign w_carry_next = (w_a_word[31] & w_b_word[31])
                      | ((w_a_word[31] ^ w_b_word[31]) & ~w_sum_word[31]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)    w_next = S_RUN;
      S_RUN:   if (w_last_word) w_next = S_DONE;
      S_DONE:  if (resp_ready)  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx        <= '0;
      r_carry      <= 1'b0;
      r_last       <= 1'b1;
      r_a          <= '0;
      r_b          <= '0;
      r_sub        <= 1'b0;
      r_id         <= 1'b0;
      r_sum        <= '0;
      r_cout       <= 1'b0;
      r_resp_id    <= 1'b0;
      r_resp_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a     <= req1_ready ? req1_a : req0_a;
            r_b     <= req1_ready ? req1_b : req0_b;
            r_sub   <= req1_ready ? req1_sub : req0_sub;
            r_carry <= req1_ready ? req1_sub : req0_sub;
            r_id    <= req1_ready;
            r_idx   <= '0;
          end
        end
        S_RUN: begin
          r_sum[32*r_idx +: 32] <= w_sum_word;
          r_carry               <= w_carry_next;
          r_idx                 <= r_idx + 1'b1;
          if (w_last_word) begin
            r_cout       <= w_carry_next;
            r_resp_id    <= r_id;
            r_last       <= r_id;
            r_resp_valid <= 1'b1;
            r_idx        <= '0;
          end
        end
        S_DONE: begin
          if (resp_ready) r_resp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_sum   = r_sum;
  assign resp_cout  = r_cout;
  assign resp_id    = r_resp_id;
endmodule

// File: tb/tb_wide_add_seq.sv
// tb/tb_wide_add_seq.sv - self-checking bench for wide_add_seq
module tb_wide_add_seq;
  localparam int NW = 4;
  localparam int W  = 32 * NW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_ready, req1_ready;
  logic [W-1:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic          req0_sub = 1'b0, req1_sub = 1'b0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [W-1:0]  resp_sum;
  logic          resp_cout;
  logic          resp_id;

  int errors = 0;
  int checks = 0;
  logic m_last = 1'b1;

  always #5 clk = ~clk;

  wide_add_seq #(.NWORDS(NW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_sum(resp_sum), .resp_cout(resp_cout), .resp_id(resp_id)
  );

  // Reference: whole-width arithmetic, carry/not-borrow in the top bit.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic sub);
    logic [W:0] bb;
    bb = {1'b0, (sub ? ~b : b)};
    return {1'b0, a} + bb + (W+1)'(sub);
  endfunction

  function automatic logic [W-1:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic issue(input int which, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sub);
    int n;
    @(negedge clk);
    if (which == 0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sub = sub;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sub = sub;
    end
    for (n = 0; n < 40; n++) begin
      #1;
      if ((which == 0) ? req0_ready : req1_ready) break;
      @(negedge clk);
    end
    if (n == 40) begin
      checks++; errors++;
      $display("FAIL accept_timeout requester=%0d never saw ready", which);
    end
    @(negedge clk);
    if (which == 0) req0_valid = 1'b0;
    else            req1_valid = 1'b0;
  endtask

  task automatic wait_resp(output int lat);
    lat = 0;
    while (!resp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic consume();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic do_op(input int which, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sub, output logic [W-1:0] s, output logic c,
                       output logic id, output int lat);
    issue(which, a, b, sub);
    wait_resp(lat);
    s = resp_sum; c = resp_cout; id = resp_id;
    consume();
    m_last = 1'(which);
  endtask

  task automatic test_reset();
    #1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready got=%b%b want=00", req0_ready, req1_ready);
    end
    checks++;
    if (resp_valid !== 1'b0 || resp_sum !== '0 || resp_cout !== 1'b0 || resp_id !== 1'b0) begin
      errors++;
      $display("FAIL reset_resp got valid=%b sum=%h cout=%b id=%b want all zero",
               resp_valid, resp_sum, resp_cout, resp_id);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL first_tie got=%b%b want r0=1 r1=0", req0_ready, req1_ready);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    m_last = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [W-1:0] a0, b0, a1, b1;
    logic s0, s1, exp_id;
    logic [W:0] e;
    int n, lat;
    a0 = rand_word(); b0 = rand_word(); s0 = 1'($urandom);
    a1 = rand_word(); b1 = rand_word(); s1 = 1'($urandom);
    @(negedge clk);
    req0_a = a0; req0_b = b0; req0_sub = s0;
    req1_a = a1; req1_b = b1; req1_sub = s1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_id = ~m_last;
      for (n = 0; n < 40; n++) begin
        #1;
        if (req0_ready || req1_ready) break;
        @(negedge clk);
      end
      checks++;
      if (req0_ready === req1_ready) begin
        errors++; $display("FAIL rr_onehot op=%0d got=%b%b want exactly one",
                           k, req0_ready, req1_ready);
      end
      checks++;
      if (req1_ready !== exp_id) begin
        errors++; $display("FAIL rr_grant op=%0d got=%b want=%b", k, req1_ready, exp_id);
      end
      @(negedge clk);
      wait_resp(lat);
      e = exp_id ? model(a1, b1, s1) : model(a0, b0, s0);
      checks++;
      if (resp_id !== exp_id || resp_sum !== e[W-1:0] || resp_cout !== e[W]) begin
        errors++;
        $display("FAIL rr_resp op=%0d got id=%b sum=%h cout=%b want id=%b sum=%h cout=%b",
                 k, resp_id, resp_sum, resp_cout, exp_id, e[W-1:0], e[W]);
      end
      consume();
      m_last = exp_id;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_directed();
    logic [W-1:0] s; logic c, id; int lat;
    do_op(0, 128'h0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'h1, 1'b0, s, c, id, lat);
    checks++;
    if (s !== 128'h0000_0001_0000_0000_0000_0000_0000_0000 || c !== 1'b0 || id !== 1'b0) begin
      errors++; $display("FAIL ripple got sum=%h cout=%b id=%b", s, c, id);
    end
    checks++;
    if (lat !== 4) begin
      errors++; $display("FAIL ripple_latency got=%0d want=4", lat);
    end
    do_op(1, {W{1'b1}}, 128'h1, 1'b0, s, c, id, lat);
    checks++;
    if (s !== '0 || c !== 1'b1 || id !== 1'b1) begin
      errors++; $display("FAIL overflow got sum=%h cout=%b id=%b want 0/1/1", s, c, id);
    end
    do_op(0, 128'h5, 128'h3, 1'b1, s, c, id, lat);
    checks++;
    if (s !== 128'h2 || c !== 1'b1) begin
      errors++; $display("FAIL sub_5_3 got sum=%h cout=%b want 2/1", s, c);
    end
    do_op(0, 128'h0, 128'h1, 1'b1, s, c, id, lat);
    checks++;
    if (s !== {W{1'b1}} || c !== 1'b0) begin
      errors++; $display("FAIL sub_0_1 got sum=%h cout=%b want ones/0", s, c);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, s; logic sub, c, id; logic [W:0] e; int lat, who;
    for (int k = 0; k < 12; k++) begin
      a = rand_word(); b = rand_word(); sub = 1'($urandom);
      if (k % 4 == 3) b = ~a;
      who = int'($urandom_range(0, 1));
      e = model(a, b, sub);
      do_op(who, a, b, sub, s, c, id, lat);
      checks++;
      if (s !== e[W-1:0] || c !== e[W] || id !== 1'(who) || lat !== 4) begin
        errors++;
        $display("FAIL random op=%0d got sum=%h cout=%b id=%b lat=%0d want sum=%h cout=%b id=%0d lat=4",
                 k, s, c, id, lat, e[W-1:0], e[W], who);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a, b, s0; logic c0; logic [W:0] e; int lat;
    a = rand_word(); b = rand_word();
    e = model(a, b, 1'b0);
    issue(0, a, b, 1'b0);
    wait_resp(lat);
    s0 = resp_sum; c0 = resp_cout;
    checks++;
    if (s0 !== e[W-1:0] || c0 !== e[W]) begin
      errors++; $display("FAIL bp_result got sum=%h cout=%b want sum=%h cout=%b",
                         s0, c0, e[W-1:0], e[W]);
    end
    req1_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      checks++;
      if (resp_valid !== 1'b1 || resp_sum !== s0 || resp_cout !== c0 ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d got valid=%b sum=%h cout=%b rdy=%b%b",
                 k, resp_valid, resp_sum, resp_cout, req0_ready, req1_ready);
      end
    end
    @(negedge clk);
    req1_valid = 1'b0;
    a = rand_word(); b = rand_word();
    req0_a = a; req0_b = b; req0_sub = 1'b1; req0_valid = 1'b1;
    resp_ready = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b0) begin
      errors++; $display("FAIL no_bypass got ready0=%b want 0", req0_ready);
    end
    @(negedge clk);
    resp_ready = 1'b0;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL bp_reaccept got ready0=%b valid=%b want 1/0", req0_ready, resp_valid);
    end
    @(negedge clk);
    req0_valid = 1'b0;
    wait_resp(lat);
    e = model(a, b, 1'b1);
    checks++;
    if (resp_sum !== e[W-1:0] || resp_cout !== e[W] || resp_id !== 1'b0 || lat !== 4) begin
      errors++; $display("FAIL bp_next got sum=%h cout=%b id=%b lat=%0d want sum=%h cout=%b",
                         resp_sum, resp_cout, resp_id, lat, e[W-1:0], e[W]);
    end
    consume();
    m_last = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    logic [W-1:0] a, b, s; logic c, id; logic [W:0] e; int lat;
    a = {rand_word() >> 32, 32'h1234_5678};
    b = {rand_word() >> 32, 32'h0000_0001};
    issue(0, a, b, 1'b0);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if (resp_valid !== 1'b0 || resp_sum !== '0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL mid_reset got valid=%b sum=%h rdy=%b%b want 0/0/00",
                         resp_valid, resp_sum, req0_ready, req1_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    m_last = 1'b1;
    a = rand_word(); b = rand_word();
    e = model(a, b, 1'b0);
    do_op(0, a, b, 1'b0, s, c, id, lat);
    checks++;
    if (s !== e[W-1:0] || c !== e[W] || id !== 1'b0 || lat !== 4) begin
      errors++; $display("FAIL post_reset got sum=%h cout=%b id=%b lat=%0d want sum=%h cout=%b id=0",
                         s, c, id, lat, e[W-1:0], e[W]);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
